// File: rtl/led_fader_pkg.sv
// Shared constants and helpers for the LED fader: default PWM width,
// full-scale level and the optional gamma brightness curve.
package led_fader_pkg;

    localparam int PWM_W_DEF = 8;

    function automatic int unsigned level_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Squared-brightness curve; full scale is pinned so "fully on" has no PWM gap.
    function automatic int unsigned gamma_map(input int unsigned level, input int unsigned w);
        int unsigned lmax;
        lmax = level_max(w);
        if (level == lmax) begin
            return lmax;
        end
        return (level * level) >> w;
    endfunction

endpackage

// File: rtl/led_fader_if.sv
// Pattern-generator side of the LED fader: request bits in, PWM pins and
// settled flag out.
interface led_fader_if #(
    parameter int N_LED = 4
);
    logic [N_LED-1:0] led_req;
    logic [N_LED-1:0] led_out;
    logic             settled;

    modport master (output led_req, input led_out, input settled);
    modport slave  (input led_req, output led_out, output settled);
endinterface

// File: rtl/led_fader_channel.sv
// One LED channel: saturating brightness ramp stepped by the shared tick and
// a registered PWM compare against the shared counter. Gamma: LED_FADER_GAMMA_EN.
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_W = PWM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_req,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    output logic [PWM_W-1:0] o_level,
    output logic             o_at_target,
    output logic             o_pwm_out
);
    localparam logic [PWM_W-1:0] LEVEL_MAX = PWM_W'(level_max(PWM_W));

    logic [PWM_W-1:0] r_level;
    logic             r_pwm_out;
    logic [PWM_W-1:0] w_lvl_eff;
    logic             w_on;

    // Level stage: one step per tick, saturating at both ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else if (i_tick) begin
            if (i_req && (r_level != LEVEL_MAX)) begin
                r_level <= r_level + PWM_W'(1);
            end else if (!i_req && (r_level != '0)) begin
                r_level <= r_level - PWM_W'(1);
            end
        end
    end

    always_comb begin
`ifdef LED_FADER_GAMMA_EN
        w_lvl_eff = PWM_W'(gamma_map(32'(r_level), PWM_W));
`else
        w_lvl_eff = r_level;
`endif
        w_on = (w_lvl_eff == LEVEL_MAX) ? 1'b1 : (i_pwm_cnt < w_lvl_eff);
    end

    // Output stage: registered pin drive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_out <= 1'b0;
        end else begin
            r_pwm_out <= w_on;
        end
    end

    assign o_level     = r_level;
    assign o_at_target = i_req ? (r_level == LEVEL_MAX) : (r_level == '0);
    assign o_pwm_out   = r_pwm_out;

endmodule

// File: rtl/led_fader.sv
// LED fader top: request register, step divider, shared PWM counter and one
// ramp/PWM channel per LED. Optional gamma curve: LED_FADER_GAMMA_EN.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int PWM_W    = PWM_W_DEF,
    parameter int STEP_DIV = 195,
    parameter int N_LED    = 4
) (
    input  logic        clk,
    input  logic        rst,
    led_fader_if.slave  io_led
);
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [N_LED-1:0] r_req_q;
    logic [DIV_W-1:0] r_div_cnt;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic             r_settled;
    logic             w_tick;
    logic [PWM_W-1:0] w_level [N_LED];
    logic [N_LED-1:0] w_at_target;
    logic [N_LED-1:0] w_pwm_out;

    assign w_tick = (r_div_cnt == DIV_LAST);

    // Input stage and timebase: request register, step divider, PWM counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q   <= '0;
            r_div_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_req_q   <= io_led.led_req;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_ch
        led_fader_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_tick      (w_tick),
            .i_req       (r_req_q[gi]),
            .i_pwm_cnt   (r_pwm_cnt),
            .o_level     (w_level[gi]),
            .o_at_target (w_at_target[gi]),
            .o_pwm_out   (w_pwm_out[gi])
        );
    end

    // Status stage: settled lags the level registers by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settled <= 1'b0;
        end else begin
            r_settled <= &w_at_target;
        end
    end

    assign io_led.led_out = w_pwm_out;
    assign io_led.settled = r_settled;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader with PWM_W=4, STEP_DIV=2: a cycle model
// queues expected pins/settled per clock and each DUT edge is compared.
module tb_led_fader;
    localparam int PWM_W    = 4;
    localparam int STEP_DIV = 2;
    localparam int N_LED    = 4;
    localparam int LMAX     = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_fader_if #(.N_LED(N_LED)) u_if ();

    led_fader #(
        .PWM_W    (PWM_W),
        .STEP_DIV (STEP_DIV),
        .N_LED    (N_LED)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_led (u_if.slave)
    );

    typedef struct packed {
        logic [N_LED-1:0] out;
        logic             settled;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               m_level[N_LED];
    logic [N_LED-1:0] m_req_q;
    int               m_div;
    int               m_pwm;
    logic [N_LED-1:0] obs_out;
    logic             obs_set;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int eff(input int l);
`ifdef LED_FADER_GAMMA_EN
        if (l == LMAX) return LMAX;
        return (l * l) >> PWM_W;
`else
        return l;
`endif
    endfunction

    // Drive one clock of stimulus, queue the model's expectation, then compare.
    task automatic cycle(input logic r, input logic [N_LED-1:0] req);
        exp_t e;
        logic all_ok;
        @(negedge clk);
        rst = r;
        u_if.led_req = req;
        e = '0;
        if (r) begin
            for (int i = 0; i < N_LED; i++) m_level[i] = 0;
            m_req_q = '0;
            m_div   = 0;
            m_pwm   = 0;
        end else begin
            all_ok = 1'b1;
            for (int i = 0; i < N_LED; i++) begin
                e.out[i] = (eff(m_level[i]) == LMAX) ? 1'b1 : (m_pwm < eff(m_level[i]));
                if (m_req_q[i] ? (m_level[i] != LMAX) : (m_level[i] != 0)) all_ok = 1'b0;
            end
            e.settled = all_ok;
            if (m_div == STEP_DIV - 1) begin
                for (int i = 0; i < N_LED; i++) begin
                    if (m_req_q[i]) begin
                        if (m_level[i] < LMAX) m_level[i]++;
                    end else if (m_level[i] > 0) begin
                        m_level[i]--;
                    end
                end
                m_div = 0;
            end else begin
                m_div++;
            end
            m_pwm   = (m_pwm + 1) % (LMAX + 1);
            m_req_q = req;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        obs_out = u_if.led_out;
        obs_set = u_if.settled;
        e = sb_q.pop_front();
        check("led_out", int'(obs_out), int'(e.out));
        check("settled", int'(obs_set), int'(e.settled));
    endtask

    // Run with a fixed request until the model reaches a level on one channel.
    task automatic ramp_until(input logic [N_LED-1:0] req, input int ch, input int target,
                              input string tag);
        int n;
        n = 0;
        while ((m_level[ch] != target) && (n < 100)) begin
            cycle(1'b0, req);
            n++;
        end
        check(tag, m_level[ch] == target ? 1 : 0, 1);
        check({tag, "_lvl"}, int'(dut.w_level[ch]), target);
    endtask

    initial begin
        int hi;
        int n;
        rst = 1'b1;
        u_if.led_req = '0;
        for (int i = 0; i < N_LED; i++) m_level[i] = 0;
        m_req_q = '0;
        m_div   = 0;
        m_pwm   = 0;

        // Reset held with all requests high
        repeat (3) cycle(1'b1, 4'hF);
        check("rst_out", int'(obs_out), 0);
        check("rst_settled", int'(obs_set), 0);

        // Ramp channel 0 to full, then one full PWM period constantly on
        ramp_until(4'b0001, 0, LMAX, "ramp_up");
        hi = 0;
        repeat (16) begin
            cycle(1'b0, 4'b0001);
            hi += int'(obs_out[0]);
        end
        check("full_duty", hi, 16);
        check("full_settled", int'(obs_set), 1);
        check("others_dark", int'(obs_out[3:1]), 0);

        // Reversal at 6, then saturate at 0 without wrapping
        cycle(1'b1, 4'b0000);
        ramp_until(4'b0001, 0, 6, "rev_up");
        repeat (20) begin
            cycle(1'b0, 4'b0000);
            check("rev_level", int'(dut.w_level[0]), m_level[0]);
        end
        check("rev_floor", int'(dut.w_level[0]), 0);
        hi = 0;
        repeat (16) begin
            cycle(1'b0, 4'b0000);
            hi += int'(obs_out[0]);
        end
        check("dark_duty", hi, 0);

        // Reset mid-ramp on channel 2
        ramp_until(4'b0100, 2, 9, "mid_ramp");
        cycle(1'b1, 4'b0100);
        check("mid_rst_lvl", int'(dut.w_level[2]), 0);
        check("mid_rst_out", int'(obs_out), 0);
        check("mid_rst_div", int'(dut.r_div_cnt), 0);

        // Simultaneous opposite ramps
        ramp_until(4'b0101, 2, LMAX, "sim_up");
        repeat (4) cycle(1'b0, 4'b0101);
        n = 0;
        while (((m_level[0] != 0) || (m_level[1] != LMAX)) && (n < 100)) begin
            cycle(1'b0, 4'b1010);
            n++;
        end
        check("sim_swap", (m_level[0] == 0 && m_level[1] == LMAX) ? 1 : 0, 1);
        repeat (2) cycle(1'b0, 4'b1010);
        check("sim_settled", int'(obs_set), 1);
        check("sim_lvl3", int'(dut.w_level[3]), LMAX);
        check("sim_lvl2", int'(dut.w_level[2]), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led_fader.md
# led_fader

Per-channel LED brightness ramp and PWM driver placed directly downstream of the LED pattern generator. Consumes the generator's 4-bit on/off pattern and drives the physical LED pins. Each channel fades linearly toward full brightness when its request bit is 1, or toward dark when it is 0, instead of switching hard. Output is a registered PWM waveform per channel.

## Interface
- `PWM_W`, 8: brightness and PWM counter width; `LEVEL_MAX = 2**PWM_W - 1`.
- `STEP_DIV`, 195: clock cycles per brightness step (≥1); a full ramp takes `LEVEL_MAX*STEP_DIV` cycles.
- `N_LED`, 4: channel count.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `led_req` in N_LED: target state per channel (1 = on), from the pattern generator.
- `led_out` out N_LED: PWM drive to pins, registered.
- `settled` out 1: high when every channel's level equals its target extreme.

## Operation
- Input stage: `led_req` is registered into `req_q` (1 cycle). All decisions use `req_q`.
- Step divider: `div_cnt` counts 0..STEP_DIV-1 and wraps. `tick` is asserted for the one cycle where `div_cnt == STEP_DIV-1`.
- Per channel, `level[i]` is PWM_W bits. It updates on `tick` only:
  - `req_q[i]=1` and `level<LEVEL_MAX`: level+1.
  - `req_q[i]=0` and `level>0`: level−1.
  - Otherwise hold. Saturates at both ends and never wraps.
- A request change mid-ramp reverses direction at the next tick from the current level, with no jump.
- PWM counter `pwm_cnt`: free-running 0..LEVEL_MAX, wraps to 0, shared by all channels.
- Compare: `on[i] = (lvl_eff[i] == LEVEL_MAX) ? 1 : (pwm_cnt < lvl_eff[i])`.
  - Level 0 is never on.
  - LEVEL_MAX is constantly on, with no one-cycle gap.
- `led_out[i] <= on[i]`.
- `settled <= &(req_q ? level==LEVEL_MAX : level==0)`, evaluated per channel.

## Timing
- Reset values:
  - `led_out=0`, `settled=0`.
  - `req_q=0`, `level=0`, `div_cnt=0`, `pwm_cnt=0`.
- Reset asserted mid-ramp: all state returns to the reset values on the next edge. Levels snap to 0 with no fade.
- Latency:
  - `led_req` → `req_q`: 1 cycle.
  - First level step: at the first `tick` after that.
  - Level → `led_out`: 1 cycle.
- First `tick` after reset release: cycle STEP_DIV-1. Ticks then recur every STEP_DIV cycles.
- `settled` updates 1 cycle after a level change. It is 1 from the second cycle after reset with `led_req=0`.
- A level change within a PWM period takes effect at the current `pwm_cnt`; no period-boundary sync is applied.

## Configuration
- `LED_FADER_GAMMA_EN`:
  - Defined: `lvl_eff = (level*level) >> PWM_W` using a 2·PWM_W-bit product, except `level==LEVEL_MAX` maps to LEVEL_MAX. This gives a perceptually linear fade.
  - Undefined: `lvl_eff = level`.
- Ramp timing and `settled` are identical in both builds; only the duty cycle differs.

## Structure
- Package `led_fader_pkg`: the `PWM_W` default, `LEVEL_MAX` function/constant, and the gamma function `gamma_map(level)`.
- Sub-module `led_fader_channel` per LED:
  - Inputs: `tick`, `req`, `pwm_cnt`.
  - Outputs: `level`, `at_target`, registered `pwm_out`.
- Top: input register, divider, PWM counter, generate loop of N_LED channels, `settled` AND-reduce.

## Test plan
All scenarios use `PWM_W=4`, `STEP_DIV=2`.
- Reset: hold `rst` 3 cycles with `led_req=4'hF` → `led_out=0` and `settled=0` throughout. Release → `level[0]` reaches 1 at cycle 2 after `req_q` is set.
- Ramp up: `led_req=4'b0001` → `level[0]` reaches 15 after 30 cycles. `led_out[0]` then stays 1 over a full 16-cycle PWM period. `settled=1`. Other channels remain 0.
- Duty check: hold `level[0]=8` (freeze `req`) → `led_out[0]` high exactly 8 of 16 cycles, without GAMMA. With `LED_FADER_GAMMA_EN`: 4 of 16 cycles.
- Reversal: ramp to 6, then drop `led_req[0]` → level goes 6,5,4… with no increment after the change. Saturates at 0 with no wrap to 15.
- Reset mid-ramp: at `level[2]=9`, assert `rst` 1 cycle → next cycle `level=0`, `led_out=0`, `div_cnt=0`.
- Simultaneous: `led_req` toggles `4'b0101`→`4'b1010` → channels 0 and 2 decrement while 1 and 3 increment on the same tick. `settled` stays 0 until all four channels reach their targets.
